counter_checker: RTL and testbench
==================================

// Module: counter_checker
//
// PURPOSE
//   Receive-side monitor for the up/down test-mode counter. Samples the counter
//   output together with the tm_reset/tm_direction controls that drove it.
//   Predicts the next count and flags mismatches. Acquires lock on a clean
//   sequence and drops it on sustained failure. Sits on the test-mode
//   observation path, alongside the counter, in the same clock domain.
//
// PARAMETERS
//   COUNT_WD    16  width of the observed count
//   LOCK_CNT    4   consecutive matches needed to enter LOCKED (>=1)
//   UNLOCK_CNT  3   consecutive mismatches in LOCKED that return to UNSYNC (>=1)
//   ERR_WD      8   width of the error counter
//
// PORTS
//   i_clk           in   1         clock
//   i_rstb          in   1         async reset, active-low
//   i_en            in   1         sample/check enable
//   i_clr           in   1         sync clear of error counter, sticky and capture
//   i_tm_reset      in   1         tm_reset applied to the counter this cycle
//   i_tm_direction  in   1         direction applied this cycle: 1=down, 0=up
//   i_count         in   COUNT_WD  observed counter output
//   o_locked        out  1         checker in LOCKED state
//   o_err           out  1         1-cycle pulse per counted mismatch
//   o_err_sticky    out  1         set by any counted mismatch; cleared by i_clr
//   o_err_count     out  ERR_WD    saturating count of counted mismatches
//
// BEHAVIOUR
//   - Reset: all outputs 0, FSM=UNSYNC, history invalid, internal counters 0.
//   - History: each cycle with i_en=1 registers i_count, i_tm_reset and
//     i_tm_direction and sets hv=1. A cycle with i_en=0 clears hv and holds
//     the FSM, counters and outputs; o_err is 0 in that cycle.
//   - Prediction, mod 2^COUNT_WD:
//     exp = prev_reset ? 0 : prev_count + (prev_dir ? all-ones : 1)
//     Wrap-around is legal: up 0xFFFF->0x0000, down 0x0000->0xFFFF.
//   - Compare: check = i_en & hv; match = check & (i_count==exp);
//     miss = check & ~match. The first sample after reset or re-enable is
//     never checked.
//   - FSM UNSYNC:
//     - match increments run_cnt; miss clears it.
//     - When run_cnt reaches LOCK_CNT, go to LOCKED and clear miss_cnt.
//     - Misses in UNSYNC are not counted as errors.
//   - FSM LOCKED:
//     - miss increments miss_cnt and is a counted error; match clears miss_cnt.
//     - When miss_cnt reaches UNLOCK_CNT, go to UNSYNC and clear run_cnt.
//       The UNLOCK_CNT-th miss is still counted.
//   - Latency: all outputs are registered. The response to the sample at
//     cycle N is visible at cycle N+1 (o_err pulse, o_err_count, o_locked).
//   - Counted error: o_err=1 for one cycle and o_err_sticky set.
//     o_err_count+1, saturating at 2^ERR_WD-1. o_err still pulses when saturated.
//   - i_clr: o_err_count=0 and o_err_sticky=0 next cycle; i_clr wins over a
//     simultaneous counted error, which is dropped from count and sticky.
//     o_err still pulses for it. i_clr does not affect FSM, hv or history.
//   - Async reset mid-sequence returns to the reset state immediately.
//
// CONFIGURATION
//   COUNTER_CHECKER_FIRST_ERR_EN
//   - Defined: adds outputs
//     o_first_exp  out  COUNT_WD  exp of first counted error
//     o_first_act  out  COUNT_WD  i_count of first counted error
//     o_first_vld  out  1         capture valid
//     Captured only when o_err_sticky is clear. Reset and i_clr clear all
//     three to 0; i_clr wins over a simultaneous capture.
//   - Not defined: these ports and the capture logic are absent; all other
//     behaviour is identical.
//
// TESTING
//   1 Lock: i_en=1, up, i_count 0,1,2,3,4 on consecutive cycles -> o_locked=1
//     the cycle after sample 4; o_err never asserted.
//   2 Wrap: locked, up 0xFFFE,0xFFFF,0x0000, then down 0x0001,0x0000,0xFFFF
//     -> no o_err, o_err_count=0.
//   3 Glitch: locked, up 10,11,13,14 -> one o_err pulse after 13 (exp 12),
//     o_err_count=1, sticky=1, stays locked, 14 matches.
//     With macro: o_first_exp=12, o_first_act=13.
//   4 tm_reset: locked, sample 0x0042 with i_tm_reset=1, then 0x0000 -> no error;
//     then 0x0043 -> o_err, o_err_count+1.
//   5 Lock loss and saturation: ERR_WD=2, locked, 4 bad samples
//     -> o_locked=0 after the 3rd, o_err_count=3, and the 4th (UNSYNC) is not counted.
//     Relock then 2 bad samples -> count stays 3.
//   6 Clear and enable: i_clr together with a miss -> o_err_count=0, sticky=0,
//     o_err pulses. Drop i_en for 2 cycles, resume at an arbitrary value
//     -> no error on the first sample.

Source files
------------

// File: rtl/counter_checker.sv
// Receive-side checker for the up/down test-mode counter: predicts each sample
// from the previous one, tracks lock and counts errors. Optional first-error
// capture ports are enabled with `define COUNTER_CHECKER_FIRST_ERR_EN.
module counter_checker #(
  parameter int COUNT_WD   = 16,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int ERR_WD     = 8
) (
  input  logic                i_clk,
  input  logic                i_rstb,
  input  logic                i_en,
  input  logic                i_clr,
  input  logic                i_tm_reset,
  input  logic                i_tm_direction,
  input  logic [COUNT_WD-1:0] i_count,
  output logic                o_locked,
  output logic                o_err,
  output logic                o_err_sticky,
  output logic [ERR_WD-1:0]   o_err_count
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
  ,
  output logic [COUNT_WD-1:0] o_first_exp,
  output logic [COUNT_WD-1:0] o_first_act,
  output logic                o_first_vld
`endif
);

  localparam int RUN_WD  = $clog2(LOCK_CNT + 1);
  localparam int MISS_WD = $clog2(UNLOCK_CNT + 1);

  typedef enum logic {
    UNSYNC = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              state;
  logic [COUNT_WD-1:0] prev_count;
  logic                prev_reset;
  logic                prev_dir;
  logic                hv;
  logic [RUN_WD-1:0]   run_cnt;
  logic [MISS_WD-1:0]  miss_cnt;

  logic [COUNT_WD-1:0] exp_count;
  logic [RUN_WD-1:0]   run_nxt;
  logic [MISS_WD-1:0]  miss_nxt;
  logic                check;
  logic                match;
  logic                miss;
  logic                counted;

  // Prediction wraps naturally in COUNT_WD bits, so 0xFFFF->0 and 0->0xFFFF are legal.
  assign exp_count = prev_reset ? '0
                   : (prev_dir ? prev_count - COUNT_WD'(1) : prev_count + COUNT_WD'(1));
  assign check     = i_en & hv;
  assign match     = check & (i_count == exp_count);
  assign miss      = check & ~match;
  assign counted   = miss & (state == LOCKED);
  assign run_nxt   = run_cnt + RUN_WD'(1);
  assign miss_nxt  = miss_cnt + MISS_WD'(1);

  // History and lock FSM. A disabled cycle only invalidates history; the FSM holds.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      state      <= UNSYNC;
      o_locked   <= 1'b0;
      prev_count <= '0;
      prev_reset <= 1'b0;
      prev_dir   <= 1'b0;
      hv         <= 1'b0;
      run_cnt    <= '0;
      miss_cnt   <= '0;
    end else if (i_en) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      prev_count <= i_count;
      prev_reset <= i_tm_reset;
      prev_dir   <= i_tm_direction;
      hv         <= 1'b1;
      if (check) begin
        case (state)
          UNSYNC: begin
            if (match) begin
              if (run_nxt == RUN_WD'(LOCK_CNT)) begin
                state    <= LOCKED;
                o_locked <= 1'b1;
                run_cnt  <= '0;
                miss_cnt <= '0;
              end else begin
                run_cnt <= run_nxt;
              end
            end else begin
              run_cnt <= '0;
            end
          end
          LOCKED: begin
            if (miss) begin
              if (miss_nxt == MISS_WD'(UNLOCK_CNT)) begin
                state    <= UNSYNC;
                o_locked <= 1'b0;
                run_cnt  <= '0;
                miss_cnt <= '0;
              end else begin
                miss_cnt <= miss_nxt;
              end
            end else begin
              miss_cnt <= '0;
            end
          end
          default: begin
            state    <= UNSYNC;
            o_locked <= 1'b0;
          end
        endcase
      end
    end else begin
      hv <= 1'b0;
    end
  end

  // Error reporting. i_clr beats a simultaneous counted error, but o_err still pulses.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      o_err        <= 1'b0;
      o_err_sticky <= 1'b0;
      o_err_count  <= '0;
    end else begin
      o_err <= counted;
      if (i_clr) begin
        o_err_sticky <= 1'b0;
        o_err_count  <= '0;
      end else if (counted) begin
        o_err_sticky <= 1'b1;
        if (o_err_count != {ERR_WD{1'b1}}) begin
          o_err_count <= o_err_count + ERR_WD'(1);
        end
      end
    end
  end

`ifdef COUNTER_CHECKER_FIRST_ERR_EN
  // First-error capture is armed while the sticky flag is clear.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      o_first_exp <= '0;
      o_first_act <= '0;
      o_first_vld <= 1'b0;
    end else if (i_clr) begin
      o_first_exp <= '0;
      o_first_act <= '0;
      o_first_vld <= 1'b0;
    end else if (counted && !o_err_sticky) begin
      o_first_exp <= exp_count;
      o_first_act <= i_count;
      o_first_vld <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_counter_checker.sv
// Scoreboard bench for counter_checker: the driver queues the expected
// registered response per sample, a monitor pops and compares one cycle later.
module tb_counter_checker;

  localparam int COUNT_WD = 16;
  localparam int ERR_WD   = 2;

  typedef struct packed {
    logic              locked;
    logic              err;
    logic              sticky;
    logic [ERR_WD-1:0] count;
  } exp_t;

  logic                i_clk = 1'b0;
  logic                i_rstb = 1'b0;
  logic                i_en = 1'b0;
  logic                i_clr = 1'b0;
  logic                i_tm_reset = 1'b0;
  logic                i_tm_direction = 1'b0;
  logic [COUNT_WD-1:0] i_count = '0;
  logic                o_locked;
  logic                o_err;
  logic                o_err_sticky;
  logic [ERR_WD-1:0]   o_err_count;
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
  logic [COUNT_WD-1:0] o_first_exp;
  logic [COUNT_WD-1:0] o_first_act;
  logic                o_first_vld;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  always #5 i_clk = ~i_clk;

  counter_checker #(
    .COUNT_WD  (COUNT_WD),
    .LOCK_CNT  (4),
    .UNLOCK_CNT(3),
    .ERR_WD    (ERR_WD)
  ) dut (
    .i_clk         (i_clk),
    .i_rstb        (i_rstb),
    .i_en          (i_en),
    .i_clr         (i_clr),
    .i_tm_reset    (i_tm_reset),
    .i_tm_direction(i_tm_direction),
    .i_count       (i_count),
    .o_locked      (o_locked),
    .o_err         (o_err),
    .o_err_sticky  (o_err_sticky),
    .o_err_count   (o_err_count)
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
    ,
    .o_first_exp   (o_first_exp),
    .o_first_act   (o_first_act),
    .o_first_vld   (o_first_vld)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one sample and queue the response expected on the following cycle.
  task automatic step(input logic en, input logic clr, input logic tmr, input logic dir,
                      input logic [COUNT_WD-1:0] cnt, input logic lk, input logic er,
                      input logic st, input logic [ERR_WD-1:0] ec);
    exp_t e;
    @(negedge i_clk);
    i_en           = en;
    i_clr          = clr;
    i_tm_reset     = tmr;
    i_tm_direction = dir;
    i_count        = cnt;
    e.locked = lk;
    e.err    = er;
    e.sticky = st;
    e.count  = ec;
    sb.push_back(e);
  endtask

  task automatic settle();
    @(posedge i_clk);
    #2;
  endtask

  // Monitor: every output cycle with a pending expectation is compared.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("locked", 32'(o_locked), 32'(e.locked));
        check("err", 32'(o_err), 32'(e.err));
        check("sticky", 32'(o_err_sticky), 32'(e.sticky));
        check("err_count", 32'(o_err_count), 32'(e.count));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge i_clk);
    check("rst_locked", 32'(o_locked), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_sticky", 32'(o_err_sticky), 32'd0);
    check("rst_count", 32'(o_err_count), 32'd0);
    i_rstb = 1'b1;

    // Lock on 0..4 counting up
    step(1, 0, 0, 0, 16'h0000, 0, 0, 0, 2'd0);
    step(1, 0, 0, 0, 16'h0001, 0, 0, 0, 2'd0);
    step(1, 0, 0, 0, 16'h0002, 0, 0, 0, 2'd0);
    step(1, 0, 0, 0, 16'h0003, 0, 0, 0, 2'd0);
    step(1, 0, 0, 0, 16'h0004, 1, 0, 0, 2'd0);

    // Wrap both ways; enable gap re-seeds history without leaving LOCKED
    step(0, 0, 0, 0, 16'hDEAD, 1, 0, 0, 2'd0);
    step(1, 0, 0, 0, 16'hFFFE, 1, 0, 0, 2'd0);
    step(1, 0, 0, 0, 16'hFFFF, 1, 0, 0, 2'd0);
    step(1, 0, 0, 0, 16'h0000, 1, 0, 0, 2'd0);
    step(1, 0, 0, 1, 16'h0001, 1, 0, 0, 2'd0);
    step(1, 0, 0, 1, 16'h0000, 1, 0, 0, 2'd0);
    step(1, 0, 0, 1, 16'hFFFF, 1, 0, 0, 2'd0);

    // Glitch: 13 where 12 is expected
    step(0, 0, 0, 0, 16'hDEAD, 1, 0, 0, 2'd0);
    step(1, 0, 0, 0, 16'd10,   1, 0, 0, 2'd0);
    step(1, 0, 0, 0, 16'd11,   1, 0, 0, 2'd0);
    step(1, 0, 0, 0, 16'd13,   1, 1, 1, 2'd1);
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
    settle();
    check("first_vld_glitch", 32'(o_first_vld), 32'd1);
    check("first_exp_glitch", 32'(o_first_exp), 32'd12);
    check("first_act_glitch", 32'(o_first_act), 32'd13);
`endif
    step(1, 0, 0, 0, 16'd14,   1, 0, 1, 2'd1);

    // tm_reset forces the next prediction to zero
    step(0, 0, 0, 0, 16'hDEAD, 1, 0, 1, 2'd1);
    step(1, 0, 1, 0, 16'h0042, 1, 0, 1, 2'd1);
    step(1, 0, 0, 0, 16'h0000, 1, 0, 1, 2'd1);
    step(1, 0, 0, 0, 16'h0043, 1, 1, 1, 2'd2);
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
    settle();
    check("first_exp_held", 32'(o_first_exp), 32'd12);
    check("first_act_held", 32'(o_first_act), 32'd13);
`endif
    step(1, 0, 0, 0, 16'h0044, 1, 0, 1, 2'd2);

    // Clear, then lose lock with saturation at 3
    step(1, 1, 0, 0, 16'h0045, 1, 0, 0, 2'd0);
    step(1, 0, 0, 0, 16'h0100, 1, 1, 1, 2'd1);
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
    settle();
    check("first_exp_recap", 32'(o_first_exp), 32'h0046);
    check("first_act_recap", 32'(o_first_act), 32'h0100);
`endif
    step(1, 0, 0, 0, 16'h0200, 1, 1, 1, 2'd2);
    step(1, 0, 0, 0, 16'h0300, 0, 1, 1, 2'd3);
    step(1, 0, 0, 0, 16'h0400, 0, 0, 1, 2'd3);
    step(1, 0, 0, 0, 16'h0401, 0, 0, 1, 2'd3);
    step(1, 0, 0, 0, 16'h0402, 0, 0, 1, 2'd3);
    step(1, 0, 0, 0, 16'h0403, 0, 0, 1, 2'd3);
    step(1, 0, 0, 0, 16'h0404, 1, 0, 1, 2'd3);
    step(1, 0, 0, 0, 16'h0500, 1, 1, 1, 2'd3);
    step(1, 0, 0, 0, 16'h0600, 1, 1, 1, 2'd3);
    step(1, 0, 0, 0, 16'h0601, 1, 0, 1, 2'd3);

    // Clear wins over a simultaneous miss; enable gap, then resume anywhere
    step(1, 1, 0, 0, 16'h0700, 1, 1, 0, 2'd0);
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
    settle();
    check("first_vld_clr", 32'(o_first_vld), 32'd0);
    check("first_exp_clr", 32'(o_first_exp), 32'd0);
    check("first_act_clr", 32'(o_first_act), 32'd0);
`endif
    step(1, 0, 0, 0, 16'h0701, 1, 0, 0, 2'd0);
    step(0, 0, 0, 0, 16'hDEAD, 1, 0, 0, 2'd0);
    step(0, 0, 0, 0, 16'hBEEF, 1, 0, 0, 2'd0);
    step(1, 0, 0, 0, 16'h1234, 1, 0, 0, 2'd0);
    step(1, 0, 0, 0, 16'h1235, 1, 0, 0, 2'd0);
    step(1, 0, 0, 0, 16'h1237, 1, 1, 1, 2'd1);

    // Async reset mid-sequence
    settle();
    check("sb_drained", 32'(sb.size()), 32'd0);
    #1;
    i_rstb = 1'b0;
    #1;
    check("async_locked", 32'(o_locked), 32'd0);
    check("async_sticky", 32'(o_err_sticky), 32'd0);
    check("async_count", 32'(o_err_count), 32'd0);
    @(negedge i_clk);
    i_rstb = 1'b1;
    step(1, 0, 0, 0, 16'h0005, 0, 0, 0, 2'd0);
    step(1, 0, 0, 0, 16'h0009, 0, 0, 0, 2'd0);
    settle();
    settle();
    check("sb_final", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
